// File: rtl/max3_stream_tracker_if.sv
// Valid/ready sample input and result output bundle for max3_stream_tracker.
interface max3_stream_tracker_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IDXW-1:0]  out_idx;
    logic [7:0]       out_frames;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_frames
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_frames
    );
endinterface

// File: rtl/max3_stream_tracker.sv
// Streaming per-frame maximum finder: LEN samples in, max / first index / frame count out.
module max3_stream_tracker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN   = 3,
    parameter int unsigned IDXW  = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    max3_stream_tracker_if.slave  bus
);
    localparam logic [IDXW-1:0] LastIdx = IDXW'(LEN - 1);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] run_max_q, run_max_d;
    logic [IDXW-1:0]  run_idx_q, run_idx_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_max_q, out_max_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic [7:0]       out_frames_q, out_frames_d;

    logic             in_fire;
    logic [WIDTH-1:0] cand_max;
    logic [IDXW-1:0]  cand_idx;

    assign in_fire = bus.in_valid && in_ready_q;

    // Running max including the current sample; strict compare keeps the earliest tie.
    always_comb begin
        cand_max = run_max_q;
        cand_idx = run_idx_q;
        if (cnt_q == '0) begin
            cand_max = bus.in_data;
            cand_idx = '0;
        end else if (bus.in_data > run_max_q) begin
            cand_max = bus.in_data;
            cand_idx = cnt_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_max_d    = run_max_q;
        run_idx_d    = run_idx_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_max_d    = out_max_q;
        out_idx_d    = out_idx_q;
        out_frames_d = out_frames_q;
        unique case (state_q)
            StAccum: begin
                // Also raises in_ready on the first edge after reset release.
                in_ready_d = 1'b1;
                if (in_fire) begin
                    run_max_d = cand_max;
                    run_idx_d = cand_idx;
                    if (cnt_q == LastIdx) begin
                        cnt_d        = '0;
                        out_max_d    = cand_max;
                        out_idx_d    = cand_idx;
                        out_valid_d  = 1'b1;
                        in_ready_d   = 1'b0;
                        out_frames_d = out_frames_q + 8'd1;
                        state_d      = StHold;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAccum;
            cnt_q        <= '0;
            run_max_q    <= '0;
            run_idx_q    <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_max_q    <= '0;
            out_idx_q    <= '0;
            out_frames_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_max_q    <= run_max_d;
            run_idx_q    <= run_idx_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_max_q    <= out_max_d;
            out_idx_q    <= out_idx_d;
            out_frames_q <= out_frames_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_max    = out_max_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_frames = out_frames_q;
endmodule
